// File: rtl/order_pkg.sv
// order_pkg: shared widths, FSM state encoding, side encodings, the trade
// payload struct and the saturating cash-update helper for order_matcher.
package order_pkg;

  localparam int unsigned PRICE_W = 8;
  localparam int unsigned POS_W   = 4;
  localparam int unsigned COUNT_W = 16;
  localparam int unsigned MISS_W  = 8;
  localparam int unsigned CASH_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    OFFER = 2'd2
  } state_t;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  typedef struct packed {
    logic               side;
    logic [PRICE_W-1:0] price;
  } trade_t;

  // Apply one fill to a signed cash balance: buys pay, sells receive; clamps at the rails.
  function automatic logic [CASH_W-1:0] cash_apply(input logic [CASH_W-1:0]  cur,
                                                   input logic               side,
                                                   input logic [PRICE_W-1:0] price);
    logic [CASH_W:0] ext;
    logic [CASH_W:0] delta;
    logic [CASH_W:0] sum;
    ext   = {cur[CASH_W-1], cur};
    delta = {{(CASH_W + 1 - PRICE_W){1'b0}}, price};
    sum   = (side == SIDE_BUY) ? (ext - delta) : (ext + delta);
    if (sum[CASH_W] != sum[CASH_W-1]) begin
      cash_apply = sum[CASH_W] ? {1'b1, {(CASH_W - 1){1'b0}}} : {1'b0, {(CASH_W - 1){1'b1}}};
    end else begin
      cash_apply = sum[CASH_W-1:0];
    end
  endfunction

endpackage

// File: rtl/tick_sync.sv
// tick_sync: two-flop synchronizer for the asynchronous quote strobe plus a
// rising-edge detector. The detector stays disarmed until the history flop
// holds a genuine post-reset sample, so a strobe already high at reset release
// never produces a tick.
// Ports:
//   clk, reset  - system clock, asynchronous active-low reset
//   i_async     - asynchronous strobe input
//   o_tick_c    - one-cycle pulse on a 0->1 of the synchronized strobe (combinational)
module tick_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_tick_c
);

  logic       r_meta;
  logic       r_sync;
  logic       r_prev;
  logic [1:0] r_fill;

  // Synchronizer chain, edge history and arm counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_fill <= 2'd0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
      if (r_fill != 2'd3) begin
        r_fill <= r_fill + 2'd1;
      end
    end
  end

  assign o_tick_c = r_sync & ~r_prev & (r_fill == 2'd3);

endmodule

// File: rtl/order_matcher.sv
// order_matcher: samples bid/ask on each quote tick, decides to buy (crossed
// book, room to go long) or sell (spread at least SPREAD_TH, holding stock),
// and offers the trade on a valid/ready handshake. Tracks position, accepted
// trade count, ticks missed while busy and, optionally, a cash balance.
// Optional feature: define ORDER_MATCHER_PNL_EN to track cash; otherwise cash is 0.
// Ports:
//   clk, reset            - system clock, asynchronous active-low reset
//   slow_clk              - asynchronous quote strobe
//   buy_price, sell_price - current bid / ask
//   trade_ready           - downstream accepts the offered trade
//   trade_valid/side/price- offered trade record (side 1=buy, 0=sell)
//   position              - units held
//   trade_count           - accepted trades, saturating
//   missed_ticks          - ticks dropped while not idle, saturating
//   cash                  - signed running cash balance
module order_matcher
  import order_pkg::*;
#(
  parameter int unsigned MAX_POS   = 8,
  parameter int unsigned SPREAD_TH = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        slow_clk,
  input  logic [7:0]  buy_price,
  input  logic [7:0]  sell_price,
  input  logic        trade_ready,
  output logic        trade_valid,
  output logic        trade_side,
  output logic [7:0]  trade_price,
  output logic [3:0]  position,
  output logic [15:0] trade_count,
  output logic [7:0]  missed_ticks,
  output logic [15:0] cash
);

  state_t               r_state;
  logic [PRICE_W-1:0]   r_bid;
  logic [PRICE_W-1:0]   r_ask;
  logic                 r_valid;
  trade_t               r_trade;
  logic [POS_W-1:0]     r_pos;
  logic [COUNT_W-1:0]   r_count;
  logic [MISS_W-1:0]    r_missed;
`ifdef ORDER_MATCHER_PNL_EN
  logic [CASH_W-1:0]    r_cash;
`endif

  logic                 w_tick;
  logic                 w_accept;
  logic                 w_buy;
  logic                 w_sell;
  logic [PRICE_W:0]     w_spread;

  tick_sync u_tick_sync (
    .clk      (clk),
    .reset    (reset),
    .i_async  (slow_clk),
    .o_tick_c (w_tick)
  );

  // Spread is computed one bit wider so a crossed book (ask < bid) reads negative.
  assign w_spread = {1'b0, r_ask} - {1'b0, r_bid};
  assign w_buy    = (r_bid >= r_ask) && (r_pos < POS_W'(MAX_POS));
  assign w_sell   = !w_spread[PRICE_W] && (w_spread[PRICE_W-1:0] >= PRICE_W'(SPREAD_TH)) &&
                    (r_pos != '0);
  assign w_accept = r_valid && trade_ready;

  // Matcher FSM with registered trade record and bookkeeping counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_bid    <= '0;
      r_ask    <= '0;
      r_valid  <= 1'b0;
      r_trade  <= '0;
      r_pos    <= '0;
      r_count  <= '0;
      r_missed <= '0;
`ifdef ORDER_MATCHER_PNL_EN
      r_cash   <= '0;
`endif
    end else begin
      if (w_tick && (r_state != IDLE) && (r_missed != {MISS_W{1'b1}})) begin
        r_missed <= r_missed + MISS_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_bid   <= buy_price;
            r_ask   <= sell_price;
            r_state <= EVAL;
          end
        end
        EVAL: begin
          if (w_buy) begin
            r_trade <= '{side: SIDE_BUY, price: r_ask};
            r_valid <= 1'b1;
            r_state <= OFFER;
          end else if (w_sell) begin
            r_trade <= '{side: SIDE_SELL, price: r_bid};
            r_valid <= 1'b1;
            r_state <= OFFER;
          end else begin
            r_state <= IDLE;
          end
        end
        OFFER: begin
          if (w_accept) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
            r_pos   <= (r_trade.side == SIDE_BUY) ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
            if (r_count != {COUNT_W{1'b1}}) begin
              r_count <= r_count + COUNT_W'(1);
            end
`ifdef ORDER_MATCHER_PNL_EN
            r_cash  <= cash_apply(r_cash, r_trade.side, r_trade.price);
`endif
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign trade_valid  = r_valid;
  assign trade_side   = r_trade.side;
  assign trade_price  = r_trade.price;
  assign position     = r_pos;
  assign trade_count  = r_count;
  assign missed_ticks = r_missed;
`ifdef ORDER_MATCHER_PNL_EN
  assign cash         = r_cash;
`else
  assign cash         = '0;
`endif

endmodule

// File: tb/tb_order_matcher.sv
// tb_order_matcher: directed scenarios plus randomized quotes/handshakes,
// checked every cycle against a transaction-level model of the matcher.
module tb_order_matcher;

  localparam int MAX_POS   = 8;
  localparam int SPREAD_TH = 20;

  logic        clk;
  logic        rst_n;
  logic        slow_clk;
  logic [7:0]  buy_price;
  logic [7:0]  sell_price;
  logic        trade_ready;
  logic        trade_valid;
  logic        trade_side;
  logic [7:0]  trade_price;
  logic [3:0]  position;
  logic [15:0] trade_count;
  logic [7:0]  missed_ticks;
  logic [15:0] cash;

  int total = 0;
  int bad   = 0;

  order_matcher #(.MAX_POS(MAX_POS), .SPREAD_TH(SPREAD_TH)) dut (
    .clk          (clk),
    .reset        (rst_n),
    .slow_clk     (slow_clk),
    .buy_price    (buy_price),
    .sell_price   (sell_price),
    .trade_ready  (trade_ready),
    .trade_valid  (trade_valid),
    .trade_side   (trade_side),
    .trade_price  (trade_price),
    .position     (position),
    .trade_count  (trade_count),
    .missed_ticks (missed_ticks),
    .cash         (cash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Quote levels seen at successive edges; a tick acts two edges after the strobe
  // is first sampled high (two-flop synchronizer), never before four edges after reset.
  int m_edge, m_pos, m_count, m_missed, m_cash, m_price, m_bid, m_ask;
  bit m_valid, m_side, m_eval, m_s1, m_s2, m_s3, m_tick, m_busy, m_acc;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_edge = 0; m_pos = 0; m_count = 0; m_missed = 0; m_cash = 0; m_price = 0;
      m_bid = 0; m_ask = 0; m_valid = 0; m_side = 0; m_eval = 0;
      m_s1 = 0; m_s2 = 0; m_s3 = 0;
    end else begin
      m_edge++;
      m_tick = (m_edge >= 4) && m_s2 && !m_s3;
      m_s3 = m_s2; m_s2 = m_s1; m_s1 = slow_clk;
      m_busy = m_valid || m_eval;
      m_acc  = m_valid && trade_ready;
      if (m_tick && m_busy) m_missed = clamp(m_missed + 1, 0, 255);
      if (m_acc) begin
        m_pos   = m_pos + (m_side ? 1 : -1);
        m_count = clamp(m_count + 1, 0, 65535);
`ifdef ORDER_MATCHER_PNL_EN
        m_cash  = clamp(m_cash + (m_side ? -m_price : m_price), -32768, 32767);
`endif
        m_valid = 0;
      end
      if (m_eval) begin
        m_eval = 0;
        if (m_bid >= m_ask && m_pos < MAX_POS) begin
          m_valid = 1; m_side = 1; m_price = m_ask;
        end else if (m_ask - m_bid >= SPREAD_TH && m_pos > 0) begin
          m_valid = 1; m_side = 0; m_price = m_bid;
        end
      end
      if (m_tick && !m_busy) begin
        m_bid = int'(buy_price); m_ask = int'(sell_price); m_eval = 1;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      total++;
      if (trade_valid !== m_valid || position !== 4'(m_pos) || trade_count !== 16'(m_count) ||
          missed_ticks !== 8'(m_missed) || cash !== 16'(m_cash) ||
          (m_valid && (trade_side !== m_side || trade_price !== 8'(m_price)))) begin
        bad++;
        $display("FAIL model t=%0t got v=%0b s=%0b p=%0d pos=%0d cnt=%0d miss=%0d cash=%0d want v=%0b s=%0b p=%0d pos=%0d cnt=%0d miss=%0d cash=%0d",
                 $time, trade_valid, trade_side, trade_price, position, trade_count, missed_ticks,
                 $signed(cash), m_valid, m_side, m_price, m_pos, m_count, m_missed, m_cash);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One quote strobe with the given prices; leaves enough idle time for a ready=1 accept.
  task automatic quote(input int b, input int s);
    buy_price = 8'(b); sell_price = 8'(s); slow_clk = 1'b1;
    cyc(2);
    slow_clk = 1'b0;
    cyc(6);
  endtask

  longint exp_cash;
  int     seen;

  initial begin
    rst_n = 1'b0; slow_clk = 1'b0; buy_price = '0; sell_price = '0; trade_ready = 1'b0;
    #23;
    chk("reset_valid", trade_valid, 0);
    chk("reset_pos", position, 0);
    chk("reset_count", trade_count, 0);
    chk("reset_price", trade_price, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(6);

    // Crossed book: buy at the ask, valid two cycles after the tick.
    buy_price = 8'd60; sell_price = 8'd58; trade_ready = 1'b1; slow_clk = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); chk("buy_latency_early", trade_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("buy_valid", trade_valid, 1);
    chk("buy_side", trade_side, 1);
    chk("buy_price", trade_price, 58);
    @(posedge clk); @(negedge clk);
`ifdef ORDER_MATCHER_PNL_EN
    exp_cash = -58;
`else
    exp_cash = 0;
`endif
    chk("buy_pos", position, 1);
    chk("buy_cash", longint'($signed(cash)), exp_cash);
    chk("buy_done", trade_valid, 0);
    cyc(1); slow_clk = 1'b0; cyc(4);

    // Wide spread with stock held: sell at the bid.
    buy_price = 8'd50; sell_price = 8'd75; slow_clk = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sell_side", trade_side, 0);
    chk("sell_price", trade_price, 50);
    @(posedge clk); @(negedge clk);
`ifdef ORDER_MATCHER_PNL_EN
    exp_cash = -8;
`endif
    chk("sell_pos", position, 0);
    chk("sell_cash", longint'($signed(cash)), exp_cash);
    chk("sell_count", trade_count, 2);
    cyc(1); slow_clk = 1'b0; cyc(4);

    // Fill to MAX_POS, then a crossed book must not trade.
    for (int i = 0; i < 8; i++) quote(100, 90);
    chk("fill_pos", position, 8);
    chk("fill_count", trade_count, 10);
    buy_price = 8'd70; sell_price = 8'd60; slow_clk = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (trade_valid) seen = 1;
    end
    chk("full_no_trade", seen, 0);
    chk("full_pos", position, 8);
    cyc(1); slow_clk = 1'b0; cyc(4);

    // Back-pressure: offer held while three ticks are dropped, then one accept.
    trade_ready = 1'b0;
    buy_price = 8'd50; sell_price = 8'd75; slow_clk = 1'b1;
    cyc(2); slow_clk = 1'b0; cyc(2);
    for (int i = 0; i < 3; i++) begin
      slow_clk = 1'b1; cyc(2); slow_clk = 1'b0; cyc(2);
    end
    cyc(4);
    chk("hold_valid", trade_valid, 1);
    chk("hold_side", trade_side, 0);
    chk("hold_price", trade_price, 50);
    chk("hold_missed", missed_ticks, 3);
    chk("hold_count", trade_count, 10);
    trade_ready = 1'b1;
    cyc(1);
    chk("accept_count", trade_count, 11);
    chk("accept_pos", position, 7);
    cyc(1);
    chk("single_accept", trade_count, 11);

    // missed_ticks saturates at 255.
    trade_ready = 1'b0;
    buy_price = 8'd50; sell_price = 8'd75; slow_clk = 1'b1;
    cyc(2); slow_clk = 1'b0; cyc(2);
    for (int i = 0; i < 300; i++) begin
      slow_clk = 1'b1; cyc(1); slow_clk = 1'b0; cyc(1);
    end
    cyc(4);
    chk("missed_sat", missed_ticks, 255);
    trade_ready = 1'b1;
    cyc(2);
    chk("sat_pos", position, 6);
    chk("sat_count", trade_count, 12);

    // Reset in the middle of an offer clears everything at once.
    trade_ready = 1'b0;
    buy_price = 8'd100; sell_price = 8'd90; slow_clk = 1'b1;
    cyc(2); slow_clk = 1'b0; cyc(2);
    chk("pre_reset_valid", trade_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", trade_valid, 0);
    chk("midrst_side", trade_side, 0);
    chk("midrst_price", trade_price, 0);
    chk("midrst_pos", position, 0);
    chk("midrst_count", trade_count, 0);
    chk("midrst_missed", missed_ticks, 0);
    chk("midrst_cash", cash, 0);
    cyc(1); rst_n = 1'b1; cyc(5);

    // Randomized quotes, strobes and back-pressure.
    for (int i = 0; i < 4000; i++) begin
      buy_price   = 8'($urandom_range(40, 90));
      sell_price  = 8'($urandom_range(40, 90));
      trade_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) slow_clk = ~slow_clk;
      cyc(1);
    end

    // Strobe already high at reset release is not a tick.
    rst_n = 1'b0; slow_clk = 1'b1; buy_price = 8'd100; sell_price = 8'd90; trade_ready = 1'b1;
    cyc(2); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (trade_valid) seen = 1;
    end
    chk("no_tick_at_release", seen, 0);
    chk("no_tick_count", trade_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/order_matcher.md
ORDER_MATCHER -- requirements
Module: order_matcher

Interface
REQ-001 SHALL have parameter MAX_POS, default 8, maximum long position in units (1..15).
REQ-002 SHALL have parameter SPREAD_TH, default 20, minimum sell_price-buy_price spread that triggers a sell.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port slow_clk  input  1  quote strobe from the order generator, asynchronous to clk.
REQ-006 SHALL have port buy_price  input  8  current bid, unsigned.
REQ-007 SHALL have port sell_price  input  8  current ask, unsigned.
REQ-008 SHALL have port trade_ready  input  1  downstream accepts the trade.
REQ-009 SHALL have port trade_valid  output  1  trade record valid.
REQ-010 SHALL have port trade_side  output  1  1=buy, 0=sell.
REQ-011 SHALL have port trade_price  output  8  execution price.
REQ-012 SHALL have port position  output  4  units held, unsigned.
REQ-013 SHALL have port trade_count  output  16  accepted trades, saturating.
REQ-014 SHALL have port missed_ticks  output  8  quote ticks dropped while busy, saturating.
REQ-015 SHALL have port cash  output  16  signed running cash balance.

Function
REQ-016 SHALL synchronize slow_clk through two flops; a tick is a 0->1 transition of the synchronized value.
REQ-017 SHALL in IDLE, on tick, capture buy_price/sell_price into registers and go to EVAL.
REQ-018 SHALL in EVAL buy if buy_price>=sell_price and position<MAX_POS (price=captured sell_price).
REQ-019 SHALL in EVAL otherwise sell if sell_price-buy_price>=SPREAD_TH and position>0 (price=captured buy_price).
REQ-020 SHALL in EVAL with neither condition return to IDLE with no output change.
REQ-021 SHALL on a trade decision go to OFFER and assert trade_valid with side/price stable; tick seen in cycle T gives trade_valid in cycle T+2.
REQ-022 SHALL hold trade_valid, trade_side, trade_price unchanged until the cycle trade_valid&&trade_ready, then return to IDLE next cycle.
REQ-023 SHALL update position (+1 buy, -1 sell) and trade_count only in the accept cycle, effective next cycle.
REQ-024 SHALL increment missed_ticks for each tick arriving outside IDLE, saturating at 255.
REQ-025 SHALL saturate trade_count at 65535; position never exceeds MAX_POS nor goes below 0.
REQ-026 SHALL treat trade_ready asserted before trade_valid as having no effect.

Reset
REQ-027 SHALL on reset low asynchronously force FSM=IDLE, sync flops=0, trade_valid=0, trade_side=0, trade_price=0, position=0, trade_count=0, missed_ticks=0, cash=0.
REQ-028 SHALL abandon an unaccepted offer on reset mid-OFFER, with no position or count update.
REQ-029 SHALL NOT detect a tick on the first synchronized sample after reset release if slow_clk is already high.

Configuration
REQ-030 SHALL with ORDER_MATCHER_PNL_EN defined update cash in the accept cycle: buy subtracts trade_price, sell adds it, saturating at -32768/+32767.
REQ-031 SHALL without ORDER_MATCHER_PNL_EN keep port cash present and tied to 0.

Structure
REQ-032 SHALL place FSM state enum (IDLE, EVAL, OFFER), price width 8, and side encodings in package order_pkg.
REQ-033 SHALL implement the synchronizer and edge detector as sub-module tick_sync.

Verification
REQ-034 SHALL cover: reset release, buy=60 sell=58, tick, trade_ready=1 -> trade_valid at T+2, side=1, price=58, position=1, cash=-58.
REQ-035 SHALL cover: position=1, buy=50 sell=75, tick, ready=1 -> side=0, price=50, position=0, cash=-8.
REQ-036 SHALL cover: buy=70 sell=60 with position=MAX_POS=8, tick -> no trade_valid, position stays 8.
REQ-037 SHALL cover: trade_ready=0 for 10 cycles during OFFER with 3 ticks -> outputs stable, missed_ticks=3, single accept.
REQ-038 SHALL cover: reset asserted mid-OFFER -> all outputs 0 immediately, trade_count=0.
REQ-039 SHALL cover: build without ORDER_MATCHER_PNL_EN, scenario REQ-034 -> cash=0, other outputs identical.
